// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: 3-cycle FETCH/DECODE/EXEC machine over a 2^AW x W internal RAM.
// Define ACC_CPU_DEBUG_EN to expose dbg_pc_o/dbg_ir_o/dbg_a_o/dbg_state_o. W must be >= AW+3.
module acc_cpu_core #(
  parameter int W  = 8,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [W-1:0]  prog_data_i,
  input  logic [W-1:0]  in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [W-1:0]  out_data_o,
  output logic          out_valid_o,
  output logic          halted_o,
  output logic          aeq0_o,
  output logic          apos_o,
  output logic          ovf_o
`ifdef ACC_CPU_DEBUG_EN
  ,
  output logic [AW-1:0] dbg_pc_o,
  output logic [W-1:0]  dbg_ir_o,
  output logic [W-1:0]  dbg_a_o,
  output logic [2:0]    dbg_state_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_INWAIT = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_HALT  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_INPUT = 3'b101,
    OP_JZ    = 3'b110,
    OP_JPOS  = 3'b111
  } opcode_t;

  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [W-1:0]    ir_q;
  logic [W-1:0]    a_q;
  logic            ovf_q;
  logic [W-1:0]    out_data_q;
  logic            out_valid_q;
  logic            halted_q;

  logic [W-1:0]    mem_q [0:(1<<AW)-1];
  logic [W-1:0]    rdata_q;
  logic [AW-1:0]   raddr;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [W-1:0]    ram_wdata;

  opcode_t         opcode;
  logic [AW-1:0]   operand;
  logic            loadable;
  logic            is_store;
  logic [W-1:0]    add_res;
  logic [W-1:0]    sub_res;
  logic            add_ovf;
  logic            sub_ovf;

  assign opcode   = opcode_t'(ir_q[W-1:W-3]);
  assign operand  = ir_q[AW-1:0];
  assign loadable = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign is_store = (state_q == S_EXEC) && (opcode == OP_STORE);

  // FETCH addresses the instruction; in DECODE the fetched word is on rdata_q, so its
  // operand field addresses the data word that EXEC then sees on rdata_q.
  assign raddr     = (state_q == S_FETCH) ? pc_q : rdata_q[AW-1:0];
  assign ram_we    = is_store || (loadable && prog_we_i);
  assign ram_waddr = is_store ? operand : prog_addr_i;
  assign ram_wdata = is_store ? a_q : prog_data_i;

  assign add_res = a_q + rdata_q;
  assign sub_res = a_q - rdata_q;
  assign add_ovf = (a_q[W-1] == rdata_q[W-1]) && (add_res[W-1] != a_q[W-1]);
  assign sub_ovf = (a_q[W-1] != rdata_q[W-1]) && (sub_res[W-1] != a_q[W-1]);

  always_ff @(posedge clk_i) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    rdata_q <= mem_q[raddr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start_i && !prog_we_i) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            a_q      <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= rdata_q;
          pc_q    <= pc_q + AW'(1);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (opcode)
            OP_HALT: begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end
            OP_LOAD:  a_q <= rdata_q;
            OP_STORE: begin
              if (operand == '1) begin
                out_data_q  <= a_q;
                out_valid_q <= 1'b1;
              end
            end
            OP_ADD: begin
              a_q   <= add_res;
              ovf_q <= add_ovf;
            end
            OP_SUB: begin
              a_q   <= sub_res;
              ovf_q <= sub_ovf;
            end
            OP_INPUT: state_q <= S_INWAIT;
            OP_JZ:    if (a_q == '0) pc_q <= operand;
            OP_JPOS:  if (!a_q[W-1]) pc_q <= operand;
            default: ;
          endcase
        end
        S_INWAIT: begin
          if (in_valid_i) begin
            a_q     <= in_data_i;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Input handshake: a word transfers on a rising edge where in_valid_i and in_ready_o are
  // both high; ready is only ever offered in INWAIT and simply mirrors valid there.
  assign in_ready_o  = (state_q == S_INWAIT) && in_valid_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = halted_q;
  assign aeq0_o      = (a_q == '0);
  assign apos_o      = ~a_q[W-1];
  assign ovf_o       = ovf_q;

`ifdef ACC_CPU_DEBUG_EN
  assign dbg_pc_o    = pc_q;
  assign dbg_ir_o    = ir_q;
  assign dbg_a_o     = a_q;
  assign dbg_state_o = state_q;
`endif

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core (W=8, AW=5): small programs with hand-computed results.
module tb_acc_cpu_core;
  localparam int W  = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [W-1:0]  prog_data = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          halted;
  logic          aeq0;
  logic          apos;
  logic          ovf;

  int checks = 0;
  int failures = 0;
  int ov_pulses = 0;
  int rdy_pulses = 0;
  int n;

  acc_cpu_core #(.W(W), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .prog_we_i   (prog_we),
    .prog_addr_i (prog_addr),
    .prog_data_i (prog_data),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .halted_o    (halted),
    .aeq0_o      (aeq0),
    .apos_o      (apos),
    .ovf_o       (ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid) ov_pulses++;
    if (in_ready) rdy_pulses++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pw(input logic [AW-1:0] a, input logic [W-1:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    ov_pulses = 0;
    rdy_pulses = 0;
  endtask

  task automatic run_to_halt(input int max_cycles, output int cycles);
    cycles = 0;
    while (!halted && cycles < max_cycles) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"}, 32'(out_data), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
    check({tag, "_aeq0"}, 32'(aeq0), 32'h1);
    check({tag, "_apos"}, 32'(apos), 32'h1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 5 + 3 stored to the output port, then halt 12 cycles after start
    pw(5'd10, 8'h05); pw(5'd11, 8'h03);
    pw(5'd0, 8'h2A); pw(5'd1, 8'h6B); pw(5'd2, 8'h5F); pw(5'd3, 8'h00);
    start_run();
    run_to_halt(50, n);
    check("add_cycles", 32'(n), 32'd12);
    check("add_halted", 32'(halted), 32'h1);
    check("add_out", 32'(out_data), 32'h08);
    check("add_pulses", 32'(ov_pulses), 32'd1);
    check("add_ovf", 32'(ovf), 32'h0);
    check("add_aeq0", 32'(aeq0), 32'h0);
    check("add_apos", 32'(apos), 32'h1);

    // prog_we wins over a same-cycle start: core stays halted
    prog_we = 1'b1; prog_addr = 5'd25; prog_data = 8'h00; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    tick();
    check("prec_halted", 32'(halted), 32'h1);

    // 0x80 - 0x01 overflows to 0x7F
    pw(5'd10, 8'h80); pw(5'd11, 8'h01); pw(5'd1, 8'h8B);
    start_run();
    run_to_halt(50, n);
    check("sub_out", 32'(out_data), 32'h7F);
    check("sub_ovf", 32'(ovf), 32'h1);
    check("sub_apos", 32'(apos), 32'h1);
    check("sub_pulses", 32'(ov_pulses), 32'd1);

    // 0x7F + 0x01 overflows to 0x80
    pw(5'd10, 8'h7F); pw(5'd1, 8'h6B);
    start_run();
    run_to_halt(50, n);
    check("addov_out", 32'(out_data), 32'h80);
    check("addov_ovf", 32'(ovf), 32'h1);
    check("addov_apos", 32'(apos), 32'h0);

    // countdown loop 3 -> 0, then store 0 and halt
    pw(5'd10, 8'h03); pw(5'd11, 8'h01);
    pw(5'd0, 8'h2A); pw(5'd1, 8'h8B); pw(5'd2, 8'hC4); pw(5'd3, 8'hE1);
    pw(5'd4, 8'h5F); pw(5'd5, 8'h00);
    start_run();
    run_to_halt(200, n);
    check("loop_cycles", 32'(n), 32'd33);
    check("loop_halted", 32'(halted), 32'h1);
    check("loop_out", 32'(out_data), 32'h00);
    check("loop_pulses", 32'(ov_pulses), 32'd1);
    check("loop_aeq0", 32'(aeq0), 32'h1);
    check("loop_ovf", 32'(ovf), 32'h0);

    // INPUT stalls until in_valid, ready pulses once, value reaches out_data
    pw(5'd0, 8'hA0); pw(5'd1, 8'h5F); pw(5'd2, 8'h00);
    start_run();
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      check("inw_ready_low", 32'(in_ready), 32'h0);
      tick();
    end
    check("inw_halted", 32'(halted), 32'h0);
    in_valid = 1'b1;
    in_data = 8'h33;
    #1 check("inw_ready_high", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    in_data = 8'h00;
    #1 check("inw_ready_drop", 32'(in_ready), 32'h0);
    run_to_halt(50, n);
    check("inw_cycles", 32'(n), 32'd6);
    check("inw_out", 32'(out_data), 32'h33);
    check("inw_rdy_pulses", 32'(rdy_pulses), 32'd1);
    check("inw_pulses", 32'(ov_pulses), 32'd1);

    // reset lands in EXEC of a STORE; prog_we while running must be ignored
    pw(5'd10, 8'h55); pw(5'd20, 8'hAA);
    pw(5'd0, 8'h2A); pw(5'd1, 8'h54); pw(5'd2, 8'h00);
    start_run();
    prog_we = 1'b1; prog_addr = 5'd20; prog_data = 8'h11;
    tick();
    prog_we = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_exec");
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_halted_after", 32'(halted), 32'h0);
    pw(5'd0, 8'h34); pw(5'd1, 8'h5F); pw(5'd2, 8'h00);
    start_run();
    run_to_halt(50, n);
    check("rst_cycles", 32'(n), 32'd9);
    check("rst_target_word", 32'(out_data), 32'hAA);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
